// File: rtl/arbitro_registrador_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbitro_registrador_pkg : state encodings and width helper for the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
package arbitro_registrador_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_GRANT  = 2'd1;
   localparam logic [1:0] ST_LOCKED = 2'd2;

   // Never returns 0, so a 1-entry range still gets a 1-bit index.
   function automatic int clog2_w(input int n);
      int r;
      r = 1;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/arbitro_registrador_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbitro_registrador_if : requester-side and register-side signals of the arbiter
// Revision 1.0
// ---------------------------------------------------------------------------
interface arbitro_registrador_if #(
   parameter int N     = 4,
   parameter int WIDTH = 8
) ();
   import arbitro_registrador_pkg::*;

   localparam int OW = clog2_w(N);

   logic [N-1:0]       req;
   logic [N-1:0]       lock;
   logic [N*WIDTH-1:0] din;
   logic [N-1:0]       gnt;
   logic [N-1:0]       ack;
   logic [WIDTH-1:0]   q;
   logic [WIDTH-1:0]   qn;
   logic [OW-1:0]      owner;
   logic               busy;

   modport master (
      output req, lock, din,
      input  gnt, ack, q, qn, owner, busy
   );

   modport slave (
      input  req, lock, din,
      output gnt, ack, q, qn, owner, busy
   );

endinterface
`default_nettype wire

// File: rtl/arbitro_registrador_rr_prioridade.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_prioridade : combinational round-robin pick, searching upward from last+1
// Revision 1.0
// ---------------------------------------------------------------------------
module rr_prioridade #(
   parameter int N  = 4,
   parameter int OW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [OW-1:0] last,
   output logic [OW-1:0] winner,
   output logic          valid
);

   logic [OW-1:0] cand;

   // Walk from the farthest slot back to the nearest so the nearest hit wins.
   always_comb begin
      winner = '0;
      valid  = 1'b0;
      cand   = '0;
      for (int k = N; k >= 1; k--) begin
         cand = OW'((int'(last) + k) % N);
         if (req[cand]) begin
            winner = cand;
            valid  = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/arbitro_registrador.sv
`default_nettype none
// ---------------------------------------------------------------------------
// arbitro_registrador : round-robin owner of one shared register, with bounded lock bursts
// Revision 1.0
// ---------------------------------------------------------------------------
module arbitro_registrador
   import arbitro_registrador_pkg::*;
#(
   parameter int N        = 4,
   parameter int WIDTH    = 8,
   parameter int MAX_LOCK = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   arbitro_registrador_if.slave  bus
);

   localparam int OW = clog2_w(N);
   localparam int CW = clog2_w(MAX_LOCK + 1);
   localparam logic [N-1:0] ONE = N'(1);

   logic [1:0]       state;
   logic [OW-1:0]    last;
   logic [OW-1:0]    owner;
   logic [CW-1:0]    count;
   logic [N-1:0]     gnt;
   logic [N-1:0]     ack;
   logic [WIDTH-1:0] q;

   logic [OW-1:0]    winner;
   logic             valid;
   logic [WIDTH-1:0] din_arr [N];

   generate
      for (genvar i = 0; i < N; i++) begin : g_unpack
         assign din_arr[i] = bus.din[i*WIDTH +: WIDTH];
      end
   endgenerate

   rr_prioridade #(
      .N  (N),
      .OW (OW)
   ) u_prio (
      .req    (bus.req),
      .last   (last),
      .winner (winner),
      .valid  (valid)
   );

   // count holds writes already done in this burst, GRANT write included.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         last  <= OW'(N - 1);
         owner <= '0;
         count <= '0;
         gnt   <= '0;
         ack   <= '0;
         q     <= '0;
      end else begin
         ack <= '0;
         case (state)
            ST_IDLE: begin
               if (valid) begin
                  gnt   <= ONE << winner;
                  owner <= winner;
                  last  <= winner;
                  state <= ST_GRANT;
               end else begin
                  gnt <= '0;
               end
            end
            ST_GRANT: begin
               if (bus.req[owner]) begin
                  q   <= din_arr[owner];
                  ack <= ONE << owner;
                  if (bus.lock[owner] && (MAX_LOCK > 1)) begin
                     count <= CW'(1);
                     state <= ST_LOCKED;
                  end else begin
                     gnt   <= '0;
                     state <= ST_IDLE;
                  end
               end else begin
                  gnt   <= '0;
                  state <= ST_IDLE;
               end
            end
            ST_LOCKED: begin
               if (bus.req[owner]) begin
                  q   <= din_arr[owner];
                  ack <= ONE << owner;
                  if (bus.lock[owner] && (count < CW'(MAX_LOCK - 1))) begin
                     count <= count + CW'(1);
                  end else begin
                     gnt   <= '0;
                     state <= ST_IDLE;
                  end
               end else begin
                  gnt   <= '0;
                  state <= ST_IDLE;
               end
            end
            default: begin
               gnt   <= '0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt   = gnt;
   assign bus.ack   = ack;
   assign bus.q     = q;
   assign bus.qn    = ~q;
   assign bus.owner = owner;
   assign bus.busy  = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_arbitro_registrador.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_arbitro_registrador : directed self-checking bench for arbitro_registrador
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_arbitro_registrador;

   logic clk   = 1'b0;
   logic rst_n = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   arbitro_registrador_if #(.N(4), .WIDTH(8)) bus ();

   arbitro_registrador #(
      .N        (4),
      .WIDTH    (8),
      .MAX_LOCK (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_din(input int idx, input logic [7:0] v);
      bus.din[idx*8 +: 8] = v;
   endtask

   initial begin
      int order [5];
      order = '{0, 1, 2, 3, 0};
      bus.req  = '0;
      bus.lock = '0;
      bus.din  = {8'h44, 8'h33, 8'h22, 8'h11};

      // Reset asserted before any clock edge
      #1 rst_n = 1'b0;
      #2;
      chk("rst_q",     bus.q,     8'h00);
      chk("rst_qn",    bus.qn,    8'hFF);
      chk("rst_gnt",   bus.gnt,   4'b0000);
      chk("rst_ack",   bus.ack,   4'b0000);
      chk("rst_busy",  bus.busy,  1'b0);
      chk("rst_owner", bus.owner, 2'd0);
      tick();
      tick();
      rst_n = 1'b1;

      // Fairness with all four requesting: 0,1,2,3,0
      bus.req = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("rr_gnt",   bus.gnt,   4'b0001 << order[i]);
         chk("rr_owner", bus.owner, order[i]);
         chk("rr_ack0",  bus.ack,   4'b0000);
         chk("rr_busy",  bus.busy,  1'b1);
         bus.req = 4'b1111;
         tick();
         chk("rr_ack",   bus.ack,   4'b0001 << order[i]);
         chk("rr_q",     bus.q,     32'h11 * (order[i] + 1));
         chk("rr_gnt0",  bus.gnt,   4'b0000);
         bus.req[order[i]] = 1'b0;
      end
      bus.req = '0;
      tick();
      chk("idle_busy", bus.busy, 1'b0);
      chk("idle_ack",  bus.ack,  4'b0000);

      // Single write by requester 2
      set_din(2, 8'hA5);
      bus.req = 4'b0100;
      tick();
      chk("sw_gnt", bus.gnt, 4'b0100);
      chk("sw_q_hold", bus.q, 8'h11);
      tick();
      chk("sw_q",   bus.q,   8'hA5);
      chk("sw_qn",  bus.qn,  8'h5A);
      chk("sw_ack", bus.ack, 4'b0100);
      bus.req = '0;
      tick();
      chk("sw_ack_end", bus.ack, 4'b0000);
      chk("sw_gnt_end", bus.gnt, 4'b0000);

      // Lock burst by requester 1 with requester 0 pending
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      set_din(1, 8'h01);
      tick();
      chk("lk_gnt", bus.gnt, 4'b0010);
      bus.req = 4'b0011;
      tick();
      chk("lk_q1",   bus.q,   8'h01);
      chk("lk_ack1", bus.ack, 4'b0010);
      chk("lk_gnt1", bus.gnt, 4'b0010);
      set_din(1, 8'h02);
      tick();
      chk("lk_q2",   bus.q,   8'h02);
      chk("lk_ack2", bus.ack, 4'b0010);
      chk("lk_gnt2", bus.gnt, 4'b0010);
      set_din(1, 8'h03);
      bus.lock = 4'b0000;
      tick();
      chk("lk_q3",   bus.q,   8'h03);
      chk("lk_ack3", bus.ack, 4'b0010);
      chk("lk_gnt3", bus.gnt, 4'b0000);
      bus.req = 4'b0001;
      tick();
      chk("lk_next_gnt", bus.gnt, 4'b0001);
      chk("lk_next_ack", bus.ack, 4'b0000);
      tick();
      chk("lk_next_q", bus.q, 8'h11);
      bus.req = '0;
      tick();

      // Lock bound: MAX_LOCK=4 writes then release, requester 2 pending
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      set_din(1, 8'h50);
      tick();
      chk("lb_gnt", bus.gnt, 4'b0010);
      bus.req = 4'b0110;
      for (int w = 0; w < 4; w++) begin
         tick();
         chk("lb_q",   bus.q,   8'h50 + w);
         chk("lb_ack", bus.ack, 4'b0010);
         chk("lb_gnt", bus.gnt, (w < 3) ? 4'b0010 : 4'b0000);
         set_din(1, 8'h51 + w);
      end
      tick();
      chk("lb_next_gnt", bus.gnt, 4'b0100);
      chk("lb_no5_ack",  bus.ack, 4'b0000);
      chk("lb_no5_q",    bus.q,   8'h53);
      tick();
      chk("lb_r2_q",   bus.q,   8'hA5);
      chk("lb_r2_ack", bus.ack, 4'b0100);
      bus.req  = '0;
      bus.lock = '0;
      tick();

      // Withdraw during GRANT
      bus.req = 4'b1000;
      tick();
      chk("wd_gnt", bus.gnt, 4'b1000);
      bus.req = '0;
      tick();
      chk("wd_ack",  bus.ack,  4'b0000);
      chk("wd_q",    bus.q,    8'hA5);
      chk("wd_gnt0", bus.gnt,  4'b0000);
      chk("wd_busy", bus.busy, 1'b0);

      // Async reset in the middle of a locked burst
      bus.req  = 4'b0010;
      bus.lock = 4'b0010;
      set_din(1, 8'h77);
      tick();
      tick();
      chk("ar_q_pre",    bus.q,    8'h77);
      chk("ar_busy_pre", bus.busy, 1'b1);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_gnt",   bus.gnt,   4'b0000);
      chk("ar_q",     bus.q,     8'h00);
      chk("ar_qn",    bus.qn,    8'hFF);
      chk("ar_busy",  bus.busy,  1'b0);
      chk("ar_owner", bus.owner, 2'd0);
      bus.req  = '0;
      bus.lock = '0;
      tick();
      rst_n = 1'b1;
      bus.req = 4'b1111;
      tick();
      chk("ar_first_gnt", bus.gnt, 4'b0001);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
